// File: rtl/riscv_mem_pkg.sv
// Shared RV32 data-memory definitions: funct3 encodings, access width decode, master indices.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam int M0_CORE   = 0;
  localparam int M1_LOADER = 1;

  // Width lives in funct3[1:0]; bit 2 only selects zero- versus sign-extension.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case ({1'b0, funct3[1:0]})
      F3_LB:   access_bytes = 3'd1;
      F3_LH:   access_bytes = 3'd2;
      F3_LW:   access_bytes = 3'd4;
      default: access_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, remembers the last winner.
module rr_arbiter2
  import riscv_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_gnt;

  always_comb begin
    if (req == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
    else              gnt = req;
  end

  // Reset favours the core on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_gnt <= 1'b1;
    else if (|gnt) last_gnt <= gnt[M1_LOADER];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between the core (M0) and the loader (M1),
// with range/alignment checking and a registered per-master response.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int MEM_SIZE = 2048,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [2:0]       m0_funct3,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [31:0]      m0_rdata,
  output logic             m0_err,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [2:0]       m1_funct3,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,
  output logic             m1_err,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       mem_funct3,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  // 33-bit end address keeps accesses near 2^32 from wrapping back into range.
  function automatic logic access_err(input logic [31:0] addr, input logic [2:0] funct3);
    logic [2:0]  nbytes;
    logic [32:0] end_addr;
    nbytes   = access_bytes(funct3);
    end_addr = {1'b0, addr} + {30'd0, nbytes};
    access_err = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7) ||
                 (end_addr > 33'(MEM_SIZE)) ||
                 ((nbytes == 3'd2) && addr[0]) ||
                 ((nbytes == 3'd4) && (addr[1:0] != 2'b00));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]  req, gnt;
  logic        any_gnt, sel_m1, sel_we, sel_err, issue;
  logic [2:0]  sel_funct3;
  logic [31:0] sel_addr, sel_wdata;

  logic [1:0]  rsp_vld_p1, rsp_err_p1;
  logic [31:0] rsp_data0_p1, rsp_data1_p1;
  logic [CNT_W-1:0] cnt_q;

  assign req = {m1_req, m0_req};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  // Request cycle: winner payload to the memory port, error check before issue.
  assign any_gnt    = |gnt;
  assign sel_m1     = gnt[M1_LOADER];
  assign sel_we     = sel_m1 ? m1_we     : m0_we;
  assign sel_funct3 = sel_m1 ? m1_funct3 : m0_funct3;
  assign sel_addr   = sel_m1 ? m1_addr   : m0_addr;
  assign sel_wdata  = sel_m1 ? m1_wdata  : m0_wdata;
  assign sel_err    = any_gnt && access_err(sel_addr, sel_funct3);
  assign issue      = any_gnt && !sel_err;

  assign m0_gnt     = gnt[M0_CORE];
  assign m1_gnt     = gnt[M1_LOADER];
  assign mem_read   = issue && !sel_we;
  // A store presented while reset is asserted must not reach memory.
  assign mem_write  = issue && sel_we && rst_n;
  assign mem_funct3 = any_gnt ? sel_funct3 : 3'd0;
  assign mem_addr   = any_gnt ? sel_addr   : 32'd0;
  assign mem_wdata  = any_gnt ? sel_wdata  : 32'd0;

  // Response stage: one-cycle rvalid pulse for the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_p1   <= 2'b00;
      rsp_err_p1   <= 2'b00;
      rsp_data0_p1 <= 32'd0;
      rsp_data1_p1 <= 32'd0;
      cnt_q        <= '0;
    end else begin
      rsp_vld_p1   <= gnt;
      rsp_err_p1   <= gnt & {2{sel_err}};
      rsp_data0_p1 <= (gnt[M0_CORE]   && mem_read) ? mem_rdata : 32'd0;
      rsp_data1_p1 <= (gnt[M1_LOADER] && mem_read) ? mem_rdata : 32'd0;
      if (m0_req && m1_req) cnt_q <= sat_inc(cnt_q);
    end
  end

  assign m0_rvalid    = rsp_vld_p1[M0_CORE];
  assign m1_rvalid    = rsp_vld_p1[M1_LOADER];
  assign m0_err       = rsp_err_p1[M0_CORE];
  assign m1_err       = rsp_err_p1[M1_LOADER];
  assign m0_rdata     = rsp_data0_p1;
  assign m1_rdata     = rsp_data1_p1;
  assign conflict_cnt = cnt_q;

endmodule
